// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory, decode and redirect signals of the fetch stage
interface fetch_sequencer_if;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rdy;
   logic        imem_valid;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic        stall;
   logic        br_taken;
   logic [15:0] br_target;
   logic        halted;
   modport master (
      output imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
      input  imem_rdy, imem_valid, imem_data, stall, br_taken, br_target
   );
   modport slave (
      input  imem_req, imem_addr, instr, instr_pc, instr_valid, halted,
      output imem_rdy, imem_valid, imem_data, stall, br_taken, br_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, fetches over req/rdy/valid, presents instructions to decode, stops on HLT
module fetch_sequencer #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic               clk,
   input logic               rst_n,
   fetch_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, HALT} state_t;
   state_t      state_q;
   logic [15:0] pc_q;
   logic [15:0] instr_q;
   logic [15:0] instr_pc_q;
   logic        kill_q;
   logic        instr_valid_q;
   logic        halted_q;
   logic        imem_req_q;
   // fetch FSM; a redirect always wins and marks any in-flight response for discard via kill_q
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         pc_q          <= RESET_PC;
         kill_q        <= 1'b0;
         instr_q       <= 16'h0000;
         instr_pc_q    <= 16'h0000;
         instr_valid_q <= 1'b0;
         halted_q      <= 1'b0;
         imem_req_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q    <= REQ;
               imem_req_q <= 1'b1;
            end
            REQ: begin
               pc_q <= bus.br_taken ? bus.br_target : pc_q;
               if (bus.imem_rdy) begin
                  state_q    <= WAIT;
                  imem_req_q <= 1'b0;
                  kill_q     <= bus.br_taken;
               end
            end
            WAIT: begin
               pc_q <= bus.br_taken ? bus.br_target : pc_q;
               if (bus.imem_valid) begin
                  kill_q <= 1'b0;
                  if (kill_q || bus.br_taken) begin
                     state_q    <= REQ;
                     imem_req_q <= 1'b1;
                  end else begin
                     instr_q       <= bus.imem_data;
                     instr_pc_q    <= pc_q;
                     instr_valid_q <= 1'b1;
                     state_q       <= OUT;
                  end
               end else if (bus.br_taken) begin
                  kill_q <= 1'b1;
               end
            end
            OUT: begin
               if (bus.br_taken) begin
                  pc_q          <= bus.br_target;
                  instr_valid_q <= 1'b0;
                  state_q       <= REQ;
                  imem_req_q    <= 1'b1;
               end else if (!bus.stall) begin
                  instr_valid_q <= 1'b0;
                  pc_q          <= pc_q + 16'd2;
                  if (instr_q[15:12] == 4'hF) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                  end else begin
                     state_q    <= REQ;
                     imem_req_q <= 1'b1;
                  end
               end
            end
            HALT: begin
               imem_req_q <= 1'b0;
            end
            default: begin
               state_q    <= IDLE;
               imem_req_q <= 1'b0;
            end
         endcase
      end
   end
   assign bus.imem_req    = imem_req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_pc    = instr_pc_q;
   assign bus.instr_valid = instr_valid_q;
   assign bus.halted      = halted_q;
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Sequences instruction fetch for the 16-bit core: owns the architectural PC register, issues requests to instruction memory over a req/rdy/valid handshake, and presents each fetched instruction with its address to decode. It sits between instruction memory and decode and applies redirects from `PC_control`, which computes taken B/BR targets from the condition code, flags, immediate and register data. It stops fetching permanently on HLT (opcode 4'hF).

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk`  in  1  single system clock, all state updates on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  16  fetch address; equals `pc` while `imem_req`=1.
- `imem_rdy`  in  1  memory accepts request this cycle (handshake = `imem_req & imem_rdy`).
- `imem_valid`  in  1  read data valid; at most one per accepted request, never in the acceptance cycle.
- `imem_data`  in  16  read data, sampled when `imem_valid`=1.
- `instr`  out  16  held instruction.
- `instr_pc`  out  16  address of `instr`; feeds `PC_control.PC_in`.
- `instr_valid`  out  1  `instr` and `instr_pc` valid.
- `stall`  in  1  decode cannot consume; instruction accepted on any cycle with `instr_valid`=1 and `stall`=0.
- `br_taken`  in  1  redirect pulse from `PC_control`.
- `br_target`  in  16  redirect PC, used as-is.
- `halted`  out  1  HLT consumed; fetch stopped.

## Operation
- States: IDLE, REQ, WAIT, OUT, HALT. Internal: `pc` (16b), `kill` (1b).
- Reset: state=IDLE, `pc`=RESET_PC, `kill`=0, `instr`=16'h0000, `instr_pc`=16'h0000, `instr_valid`=0, `halted`=0, `imem_req`=0. Reset mid-operation discards everything, including an in-flight request.
- IDLE: go to REQ unconditionally.
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_rdy` go to WAIT; otherwise hold, keeping the address stable.
- WAIT: on `imem_valid`:
  - `kill`=1: discard data, clear `kill`, go to REQ.
  - `kill`=0: `instr`<=`imem_data`, `instr_pc`<=`pc`, `instr_valid`<=1, go to OUT.
- OUT: hold `instr` and `instr_valid` while `stall`=1. On accept:
  - `instr_valid`<=0 and `pc`<=`pc`+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
  - If `instr[15:12]`==4'hF, go to HALT; otherwise go to REQ.
- HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. Exit only by reset.
- Redirect (`br_taken`=1) has priority over everything except reset. It always sets `pc`<=`br_target`; per state:
  - REQ without `imem_rdy`: stay in REQ, new address driven next cycle.
  - REQ with `imem_rdy` (old address accepted): set `kill`, go to WAIT.
  - WAIT: set `kill` (the response is discarded), stay in WAIT. If `imem_valid` arrives in the same cycle, drop the data and go to REQ with `kill`=0.
  - OUT: `instr_valid`<=0, go to REQ. The +2 increment and HLT detection are suppressed, even when `stall`=0.
  - IDLE, HALT: ignored.
- Redirect with target == current `pc` behaves identically; no special case.

## Timing
- All outputs are decoded from registered state or registers; there is no combinational path from inputs to outputs.
- First `imem_req` appears in the 2nd cycle after `rst_n` is sampled high (IDLE occupies one cycle).
- Minimum fetch-to-present latency: accept at cycle t, `imem_valid` at t+1, `instr_valid`=1 at t+2.
- Zero-stall throughput: one instruction per 3 cycles (REQ, WAIT, OUT).
- Redirect at cycle t in OUT: `imem_req` with `imem_addr`=`br_target` at t+1.
- Redirect in WAIT: target request issues the cycle after the killed response returns.
- `halted` rises the cycle after HLT is accepted; no `imem_req` is issued after that.

## Test plan
- Reset release, memory always ready, 1-cycle data, no stall, four non-branch words -> `instr_pc` = 0000, 0002, 0004, 0006; each `instr_valid` one cycle wide, spaced 3 cycles apart.
- `stall` high for 4 cycles with `instr`=16'h1234 valid -> `instr`, `instr_pc` and `instr_valid` stable, no `imem_req`; after release next fetch address = `instr_pc`+2.
- `br_taken` with `br_target`=16'h0040 while in WAIT; old response 16'hAAAA arrives 3 cycles later -> 16'hAAAA never presented; next `imem_addr`=0040; next `instr_pc`=0040.
- `br_taken` (target 16'h0100) in the same cycle as `imem_rdy` in REQ -> accepted response is dropped, then fetch from 0100.
- Fetch 16'hF000 at PC 0008, accepted -> `halted`=1 next cycle; `imem_req` stays 0 for 20 cycles; `br_taken` ignored. Same HLT accepted together with `br_taken` -> no halt, fetch from target.
- `RESET_PC`=16'hFFFE, non-branch word -> next fetch address 16'h0000. Reset asserted in WAIT -> all outputs return to reset values, and a late `imem_valid` is ignored.
